// File: rtl/fan_ctrl_pkg.sv
// Shared types and helpers for the fan-controller MAC datapath.
// No timing of its own; holds the FSM encoding and the width helper.
// No flow control of its own.
package fan_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mac_state_t;

    // Step count for the default geometry (B_W=4, one bit per tick).
    localparam int unsigned DEF_B_W   = 4;
    localparam int unsigned DEF_BPS   = 1;
    localparam int unsigned STEPS     = DEF_B_W / DEF_BPS;

    // Smallest r with 2**r >= v.
    function automatic int unsigned clogb2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/clk_tick_divider.sv
// Prescaler: emits a one-cycle tick every CLK_DIV clk_i cycles.
// Latency: first tick CLK_DIV-1 cycles after a clear (every cycle when CLK_DIV=1).
// Backpressure: none; free-running, restarted by clr.
module clk_tick_divider
    import fan_ctrl_pkg::*;
#(
    parameter int unsigned CLK_DIV = 50
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? clogb2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/bit_serial_mac.sv
// Shift-add multiply-accumulate, BITS_PER_STEP multiplier bits per prescaled tick.
// Latency: done_o in the cycle after edge STEPS*CLK_DIV counted from the start edge.
// Backpressure: start_i is dropped whenever busy_o=1; no queueing.
module bit_serial_mac
    import fan_ctrl_pkg::*;
#(
    parameter int unsigned A_W           = 4,
    parameter int unsigned B_W           = 4,
    parameter int unsigned ACC_W         = 12,
    parameter int unsigned BITS_PER_STEP = 1,
    parameter int unsigned CLK_DIV       = 50
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             acc_i,
    input  logic             signed_i,
    input  logic [A_W-1:0]   a_i,
    input  logic [B_W-1:0]   b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [ACC_W-1:0] result_o,
    output logic             ovf_o
);

    localparam int unsigned BPS     = BITS_PER_STEP;
    localparam int unsigned N_STEPS = B_W / BPS;
    localparam int unsigned STEP_W  = (N_STEPS > 1) ? clogb2(N_STEPS) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_STEPS - 1);

    mac_state_t        state_q, state_d;
    logic [ACC_W-1:0]  a_q;
    logic [B_W-1:0]    b_q;
    logic              sgn_q;
    logic [STEP_W-1:0] step_q;
    logic [ACC_W-1:0]  acc_q;
    logic              ovf_acc_q;
    logic [ACC_W-1:0]  res_q;
    logic              ovf_q;

    logic              start_ok;
    logic              tick;
    logic              run_tick;
    logic              last_step;
    logic [ACC_W-1:0]  a_ext;
    logic [BPS-1:0]    slice;
    logic [ACC_W-1:0]  slice_ext;
    logic [ACC_W-1:0]  prod;
    logic [ACC_W-1:0]  addend;
    logic [ACC_W:0]    sum;
    logic              ovf_add;

    assign start_ok  = (state_q == IDLE) && start_i;
    assign run_tick  = (state_q == RUN) && tick;
    assign last_step = (step_q == LAST_STEP);

    clk_tick_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr   (start_ok),
        .tick  (tick)
    );

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (tick && last_step) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        case (state_q)
            RUN:     busy_o = 1'b1;
            DONE: begin
                busy_o = 1'b1;
                done_o = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        a_ext = '0;
        if (signed_i) a_ext = {{(ACC_W-A_W){a_i[A_W-1]}}, a_i};
        else          a_ext = {{(ACC_W-A_W){1'b0}}, a_i};
    end

    // The top slice of a signed multiplier carries negative weight.
    always_comb begin
        slice     = b_q[BPS-1:0];
        slice_ext = {{(ACC_W-BPS){1'b0}}, slice};
        if (sgn_q && last_step) slice_ext = {{(ACC_W-BPS){slice[BPS-1]}}, slice};
        prod   = a_q * slice_ext;
        addend = prod << (32'(step_q) * BPS);
        sum    = {1'b0, acc_q} + {1'b0, addend};
        if (sgn_q) ovf_add = (acc_q[ACC_W-1] == addend[ACC_W-1]) &&
                             (sum[ACC_W-1] != acc_q[ACC_W-1]);
        else       ovf_add = sum[ACC_W];
    end

    // Overflow accumulates privately during RUN and is published with the result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q       <= '0;
            b_q       <= '0;
            sgn_q     <= 1'b0;
            step_q    <= '0;
            acc_q     <= '0;
            ovf_acc_q <= 1'b0;
            res_q     <= '0;
            ovf_q     <= 1'b0;
        end else if (start_ok) begin
            a_q    <= a_ext;
            b_q    <= b_i;
            sgn_q  <= signed_i;
            step_q <= '0;
            if (!acc_i) begin
                acc_q     <= '0;
                ovf_acc_q <= 1'b0;
                ovf_q     <= 1'b0;
            end
        end else if (run_tick) begin
            acc_q  <= sum[ACC_W-1:0];
            b_q    <= b_q >> BPS;
            step_q <= step_q + 1'b1;
            if (ovf_add) ovf_acc_q <= 1'b1;
            if (last_step) begin
                res_q <= sum[ACC_W-1:0];
                ovf_q <= ovf_acc_q | ovf_add;
            end
        end
    end

    assign result_o = res_q;
    assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_bit_serial_mac.sv
// Directed and randomized checks of bit_serial_mac in three geometries against an arithmetic model.
module tb_bit_serial_mac;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       acc_in, sgn_in;
    logic [3:0] a_in, b_in;
    logic       st0, st1, st2;
    logic       busy0, done0, ovf0;
    logic       busy1, done1, ovf1;
    logic       busy2, done2, ovf2;
    logic [11:0] res0;
    logic [7:0]  res1;
    logic [11:0] res2;

    bit_serial_mac #(.A_W(4), .B_W(4), .ACC_W(12), .BITS_PER_STEP(1), .CLK_DIV(50)) dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(st0), .acc_i(acc_in), .signed_i(sgn_in),
        .a_i(a_in), .b_i(b_in), .busy_o(busy0), .done_o(done0), .result_o(res0), .ovf_o(ovf0));

    bit_serial_mac #(.A_W(4), .B_W(4), .ACC_W(8), .BITS_PER_STEP(1), .CLK_DIV(50)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(st1), .acc_i(acc_in), .signed_i(sgn_in),
        .a_i(a_in), .b_i(b_in), .busy_o(busy1), .done_o(done1), .result_o(res1), .ovf_o(ovf1));

    bit_serial_mac #(.A_W(4), .B_W(4), .ACC_W(12), .BITS_PER_STEP(2), .CLK_DIV(1)) dut2 (
        .clk_i(clk), .rst_i(rst), .start_i(st2), .acc_i(acc_in), .signed_i(sgn_in),
        .a_i(a_in), .b_i(b_in), .busy_o(busy2), .done_o(done2), .result_o(res2), .ovf_o(ovf2));

    int errors = 0;
    int checks = 0;

    longint m_acc [3];
    longint m_res [3];
    bit     m_ovf [3];

    function automatic int cfg_w(input int k);
        return (k == 1) ? 8 : 12;
    endfunction
    function automatic int cfg_bps(input int k);
        return (k == 2) ? 2 : 1;
    endfunction
    function automatic int cfg_div(input int k);
        return (k == 2) ? 1 : 50;
    endfunction

    function automatic longint get_res(input int k);
        case (k)
            0: return longint'(res0);
            1: return longint'(res1);
            default: return longint'(res2);
        endcase
    endfunction
    function automatic longint get_busy(input int k);
        case (k)
            0: return longint'(busy0);
            1: return longint'(busy1);
            default: return longint'(busy2);
        endcase
    endfunction
    function automatic longint get_done(input int k);
        case (k)
            0: return longint'(done0);
            1: return longint'(done1);
            default: return longint'(done2);
        endcase
    endfunction
    function automatic longint get_ovf(input int k);
        case (k)
            0: return longint'(ovf0);
            1: return longint'(ovf1);
            default: return longint'(ovf2);
        endcase
    endfunction

    task automatic set_start(input int k, input logic v);
        case (k)
            0: st0 = v;
            1: st1 = v;
            default: st2 = v;
        endcase
    endtask

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint to_s(input longint x, input int w);
        return (x >= (longint'(1) << (w - 1))) ? x - (longint'(1) << w) : x;
    endfunction

    // Reference: signed-digit multiply as a sum of weighted partial products, one add per step.
    task automatic model_op(input int k, input int a, input int b, input bit sgn, input bit accum);
        int w, bps, steps;
        longint md, av, sl, part, s;
        w = cfg_w(k); bps = cfg_bps(k); steps = 4 / bps;
        md = longint'(1) << w;
        if (!accum) begin m_acc[k] = 0; m_ovf[k] = 0; end
        av = sgn ? to_s(longint'(a), 4) : longint'(a);
        for (int st = 0; st < steps; st++) begin
            sl = longint'((b >> (st * bps)) & ((1 << bps) - 1));
            if (sgn && st == steps - 1) sl = to_s(sl, bps);
            part = (av * sl * (longint'(1) << (st * bps))) & (md - 1);
            if (sgn) begin
                s = to_s(m_acc[k], w) + to_s(part, w);
                if (s < -(md / 2) || s >= md / 2) m_ovf[k] = 1;
            end else begin
                s = m_acc[k] + part;
                if (s >= md) m_ovf[k] = 1;
            end
            m_acc[k] = s & (md - 1);
        end
        m_res[k] = m_acc[k];
    endtask

    task automatic run_op(input int k, input int a, input int b, input bit sgn, input bit accum,
                          input int pulse_at, input string tag);
        int lat, budget;
        longint res_before, post_busy, post_done;
        bit held;
        budget = cfg_div(k) * (4 / cfg_bps(k));
        res_before = get_res(k);
        model_op(k, a, b, sgn, accum);
        @(negedge clk);
        a_in = 4'(a); b_in = 4'(b); sgn_in = sgn; acc_in = accum;
        set_start(k, 1'b1);
        @(posedge clk); #1;
        set_start(k, 1'b0);
        a_in = 4'($urandom_range(0, 15)); b_in = 4'($urandom_range(0, 15));
        sgn_in = 1'($urandom_range(0, 1));
        chk({tag, "_busy_start"}, get_busy(k), 1);
        lat = -1; held = 1; post_busy = -1; post_done = -1;
        for (int n = 1; n <= budget + 5; n++) begin
            @(posedge clk); #1;
            set_start(k, 1'b0);
            if (lat >= 0) begin
                post_busy = get_busy(k);
                post_done = get_done(k);
                break;
            end
            if (get_done(k) == 1) lat = n;
            else if (get_res(k) != res_before) held = 0;
            if (n == pulse_at) begin
                set_start(k, 1'b1);
                a_in = 4'($urandom_range(0, 15)); b_in = 4'($urandom_range(0, 15));
                acc_in = 1'($urandom_range(0, 1));
            end
        end
        chk({tag, "_latency"}, longint'(lat), longint'(budget));
        chk({tag, "_result"}, get_res(k), m_res[k]);
        chk({tag, "_ovf"}, get_ovf(k), longint'(m_ovf[k]));
        chk({tag, "_result_held"}, longint'(held), 1);
        chk({tag, "_idle_after"}, post_busy * 2 + post_done, 0);
    endtask

    initial begin
        longint dones;
        rst = 1'b1; st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
        acc_in = 1'b0; sgn_in = 1'b0; a_in = '0; b_in = '0;
        for (int k = 0; k < 3; k++) begin m_acc[k] = 0; m_res[k] = 0; m_ovf[k] = 0; end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_busy", get_busy(k), 0);
            chk("rst_done", get_done(k), 0);
            chk("rst_result", get_res(k), 0);
            chk("rst_ovf", get_ovf(k), 0);
        end
        @(negedge clk) rst = 1'b0;

        // Default geometry, signed and unsigned corners, issued back-to-back.
        run_op(0, 13, 5, 1, 0, -1, "s_m3x5");
        chk("s_m3x5_const", get_res(0), 12'hFF1);
        run_op(0, 8, 8, 1, 0, -1, "s_m8xm8");
        chk("s_m8xm8_const", get_res(0), 12'h040);
        run_op(0, 15, 15, 0, 0, -1, "u_15x15");
        chk("u_15x15_const", get_res(0), 12'h0E1);
        run_op(0, 8, 8, 0, 0, -1, "u_8x8");
        chk("u_8x8_const", get_res(0), 12'h040);

        // Narrow accumulator: accumulate to overflow, sticky, then clear by a fresh start.
        run_op(1, 7, 7, 1, 0, -1, "acc1");
        chk("acc1_const", get_res(1), 49);
        run_op(1, 7, 7, 1, 1, -1, "acc2");
        chk("acc2_const", get_res(1), 98);
        run_op(1, 7, 7, 1, 1, -1, "acc3");
        chk("acc3_const", get_res(1), 8'h93);
        chk("acc3_ovf_const", get_ovf(1), 1);
        run_op(1, 0, 0, 1, 1, -1, "acc4_sticky");
        chk("acc4_ovf_const", get_ovf(1), 1);
        run_op(1, 1, 1, 1, 0, -1, "acc_clear");
        chk("acc_clear_const", get_res(1), 1);
        chk("acc_clear_ovf_const", get_ovf(1), 0);

        // Starts during RUN and during the done cycle are ignored.
        run_op(0, 6, 11, 1, 0, 20, "pulse_run");
        run_op(0, 9, 3, 0, 0, 200, "pulse_done");

        // Reset at edge 100 aborts the operation.
        @(negedge clk);
        a_in = 4'd5; b_in = 4'd7; sgn_in = 1'b0; acc_in = 1'b0; st0 = 1'b1;
        @(posedge clk); #1;
        st0 = 1'b0;
        repeat (99) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin m_acc[k] = 0; m_res[k] = 0; m_ovf[k] = 0; end
        chk("abort_busy", get_busy(0), 0);
        chk("abort_result", get_res(0), 0);
        chk("abort_ovf", get_ovf(0), 0);
        dones = 0;
        for (int n = 0; n < 300; n++) begin
            @(posedge clk); #1;
            dones += get_done(0);
        end
        chk("abort_no_done", dones, 0);

        // Two bits per tick, tick every cycle.
        run_op(2, 9, 6, 1, 0, -1, "bps2_m7x6");
        chk("bps2_m7x6_const", get_res(2), 12'hFD6);
        run_op(2, 15, 15, 0, 0, -1, "bps2_15x15");
        chk("bps2_15x15_const", get_res(2), 225);

        for (int i = 0; i < 40; i++)
            run_op(2, $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 3) != 0), -1, "rnd2");
        for (int i = 0; i < 8; i++)
            run_op(1, $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 3) != 0), -1, "rnd1");
        for (int i = 0; i < 4; i++)
            run_op(0, $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), -1, "rnd0");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
